// File: rtl/decoder_seq.sv
// decoder_seq: registered N-to-2^N decoder driven by an index sequencer.
// The index is loaded directly or stepped up/down with wrap-around, with an
// optional prescaler so that several step pulses make one advance. The
// decoded vector is one-hot or thermometer and is registered from the same
// next-state value as the index, so out always agrees with index.
module decoder_seq #(
    parameter int SEL_W    = 3,   // index width, 1..6
    parameter int STEP_DIV = 1    // accepted step pulses per advance, 1..255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   step,
    input  logic                   dir,
    input  logic                   therm,
    input  logic                   en,
    output logic [(1<<SEL_W)-1:0]  out,
    output logic [SEL_W-1:0]       index,
    output logic                   valid,
    output logic                   wrap
);

    localparam int OUT_W = 1 << SEL_W;
    localparam int PRE_W = 8;

    // Prescaler value at which the next honoured step advances the index.
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [SEL_W-1:0] INDEX_MAX = {SEL_W{1'b1}};

    // Output shaping applied to the index.
    typedef enum logic {
        MODE_ONEHOT = 1'b0,
        MODE_THERM  = 1'b1
    } out_mode_e;

    // Step direction as seen on dir.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_cnt_nxt;
    logic [SEL_W-1:0] index_nxt;
    logic             valid_nxt;
    logic             wrap_nxt;
    logic [OUT_W-1:0] out_nxt;
    logic             step_ok;
    logic             advance;

    // Decode an index into one-hot or thermometer form.
    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx,
                                                input out_mode_e      mode);
        logic [OUT_W-1:0] vec;
        vec = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (mode == MODE_THERM)
                vec[i] = (SEL_W'(i) <= idx);
            else
                vec[i] = (SEL_W'(i) == idx);
        end
        return vec;
    endfunction

    // A step only counts when an index has been loaded and no load competes.
    assign step_ok = step && valid && !load;
    assign advance = step_ok && (pre_cnt == PRE_LAST);

    // Next-state for index, prescaler, valid, wrap and the decoded vector.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        index_nxt   = index;
        pre_cnt_nxt = pre_cnt;
        valid_nxt   = valid;
        wrap_nxt    = 1'b0;
        out_nxt     = '0;

        if (load) begin
            index_nxt   = sel;
            valid_nxt   = 1'b1;
            pre_cnt_nxt = '0;
        end else if (step_ok) begin
            if (advance) begin
                pre_cnt_nxt = '0;
                if (dir_e'(dir) == DIR_DOWN) begin
                    index_nxt = index - 1'b1;
                    wrap_nxt  = (index == '0);
                end else begin
                    index_nxt = index + 1'b1;
                    wrap_nxt  = (index == INDEX_MAX);
                end
            end else begin
                pre_cnt_nxt = pre_cnt + 1'b1;
            end
        end

        if (en && valid_nxt)
            out_nxt = decode(index_nxt, out_mode_e'(therm));
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking so every register updates from pre-edge values.
        if (reset) begin
            index   <= '0;
            pre_cnt <= '0;
            valid   <= 1'b0;
            wrap    <= 1'b0;
            out     <= '0;
        end else begin
            index   <= index_nxt;
            pre_cnt <= pre_cnt_nxt;
            valid   <= valid_nxt;
            wrap    <= wrap_nxt;
            out     <= out_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_seq.sv
// Directed testbench for decoder_seq: one instance with STEP_DIV=1 and one
// with STEP_DIV=2 share all inputs; each task checks its own scenario.
module tb_decoder_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load  = 1'b0;
    logic [2:0] sel   = 3'd0;
    logic       step  = 1'b0;
    logic       dir   = 1'b0;
    logic       therm = 1'b0;
    logic       en    = 1'b1;

    logic [7:0] out1, out2;
    logic [2:0] idx1, idx2;
    logic       valid1, valid2;
    logic       wrap1, wrap2;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    decoder_seq #(.SEL_W(3), .STEP_DIV(1)) dut1 (
        .clock(clock), .reset(reset), .load(load), .sel(sel), .step(step),
        .dir(dir), .therm(therm), .en(en),
        .out(out1), .index(idx1), .valid(valid1), .wrap(wrap1)
    );

    decoder_seq #(.SEL_W(3), .STEP_DIV(2)) dut2 (
        .clock(clock), .reset(reset), .load(load), .sel(sel), .step(step),
        .dir(dir), .therm(therm), .en(en),
        .out(out2), .index(idx2), .valid(valid2), .wrap(wrap2)
    );

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; step = 1'b0; en = 1'b1; therm = 1'b0;
        cyc();
        reset = 1'b0;
        total++; if (idx1 !== 3'd0) begin bad++; $display("FAIL reset_index got=%0d want=0", idx1); end
        total++; if (out1 !== 8'h00) begin bad++; $display("FAIL reset_out got=%h want=00", out1); end
        total++; if (valid1 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid1); end
        total++; if (wrap1 !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap1); end
        step = 1'b1; dir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total++; if (idx1 !== 3'd0 || valid1 !== 1'b0 || wrap1 !== 1'b0 || out1 !== 8'h00) begin
                bad++; $display("FAIL step_unloaded_%0d got idx=%0d valid=%b wrap=%b out=%h want idx=0 valid=0 wrap=0 out=00",
                                i, idx1, valid1, wrap1, out1);
            end
        end
        step = 1'b0;
    endtask

    task automatic test_load();
        load = 1'b1; sel = 3'd5; therm = 1'b0; en = 1'b1;
        cyc();
        load = 1'b0;
        total++; if (idx1 !== 3'd5) begin bad++; $display("FAIL load_index got=%0d want=5", idx1); end
        total++; if (out1 !== 8'b0010_0000) begin bad++; $display("FAIL load_onehot got=%b want=00100000", out1); end
        total++; if (valid1 !== 1'b1) begin bad++; $display("FAIL load_valid got=%b want=1", valid1); end
        therm = 1'b1;
        total++; if (out1 !== 8'b0010_0000) begin bad++; $display("FAIL therm_before_edge got=%b want=00100000", out1); end
        cyc();
        total++; if (out1 !== 8'b0011_1111) begin bad++; $display("FAIL load_therm got=%b want=00111111", out1); end
        load = 1'b1; sel = 3'd0;
        cyc();
        total++; if (out1 !== 8'b0000_0001) begin bad++; $display("FAIL therm_idx0 got=%b want=00000001", out1); end
        sel = 3'd7;
        cyc();
        load = 1'b0; therm = 1'b0;
        total++; if (out1 !== 8'b1111_1111) begin bad++; $display("FAIL therm_idx7 got=%b want=11111111", out1); end
    endtask

    task automatic test_wrap();
        load = 1'b1; sel = 3'd6;
        cyc();
        load = 1'b0; step = 1'b1; dir = 1'b0;
        cyc();
        total++; if (idx1 !== 3'd7 || wrap1 !== 1'b0 || out1 !== 8'h80) begin
            bad++; $display("FAIL up_to7 got idx=%0d wrap=%b out=%h want idx=7 wrap=0 out=80", idx1, wrap1, out1);
        end
        cyc();
        total++; if (idx1 !== 3'd0 || wrap1 !== 1'b1 || out1 !== 8'h01) begin
            bad++; $display("FAIL up_wrap got idx=%0d wrap=%b out=%h want idx=0 wrap=1 out=01", idx1, wrap1, out1);
        end
        step = 1'b0;
        cyc();
        total++; if (idx1 !== 3'd0 || wrap1 !== 1'b0) begin
            bad++; $display("FAIL wrap_pulse got idx=%0d wrap=%b want idx=0 wrap=0", idx1, wrap1);
        end
        step = 1'b1; dir = 1'b1;
        cyc();
        total++; if (idx1 !== 3'd7 || wrap1 !== 1'b1 || out1 !== 8'h80) begin
            bad++; $display("FAIL down_wrap got idx=%0d wrap=%b out=%h want idx=7 wrap=1 out=80", idx1, wrap1, out1);
        end
        cyc();
        total++; if (idx1 !== 3'd6 || wrap1 !== 1'b0) begin
            bad++; $display("FAIL down_step got idx=%0d wrap=%b want idx=6 wrap=0", idx1, wrap1);
        end
        step = 1'b0; dir = 1'b0;
    endtask

    task automatic test_load_step();
        // Leave wrap high first so the load must clear it.
        load = 1'b1; sel = 3'd7;
        cyc();
        load = 1'b0; step = 1'b1; dir = 1'b0;
        cyc();
        total++; if (wrap1 !== 1'b1) begin bad++; $display("FAIL prewrap got=%b want=1", wrap1); end
        load = 1'b1; sel = 3'd3; step = 1'b1; dir = 1'b0;
        cyc();
        load = 1'b0; step = 1'b0;
        total++; if (idx1 !== 3'd3 || wrap1 !== 1'b0 || out1 !== 8'h08) begin
            bad++; $display("FAIL load_step got idx=%0d wrap=%b out=%h want idx=3 wrap=0 out=08", idx1, wrap1, out1);
        end
        en = 1'b0;
        cyc();
        total++; if (out1 !== 8'h00 || idx1 !== 3'd3) begin
            bad++; $display("FAIL en_off got out=%h idx=%0d want out=00 idx=3", out1, idx1);
        end
        en = 1'b1;
        total++; if (out1 !== 8'h00) begin bad++; $display("FAIL en_before_edge got=%h want=00", out1); end
        cyc();
        total++; if (out1 !== 8'b0000_1000) begin bad++; $display("FAIL en_on got=%b want=00001000", out1); end
    endtask

    task automatic test_prescale();
        load = 1'b1; sel = 3'd0;
        cyc();
        load = 1'b0; step = 1'b1; dir = 1'b0;
        cyc();
        total++; if (idx2 !== 3'd0) begin bad++; $display("FAIL div2_step1 got=%0d want=0", idx2); end
        cyc();
        total++; if (idx2 !== 3'd1 || out2 !== 8'h02) begin
            bad++; $display("FAIL div2_step2 got idx=%0d out=%h want idx=1 out=02", idx2, out2);
        end
        cyc();
        total++; if (idx2 !== 3'd1) begin bad++; $display("FAIL div2_step3 got=%0d want=1", idx2); end
        total++; if (idx1 !== 3'd3) begin bad++; $display("FAIL div1_step3 got=%0d want=3", idx1); end
        // Prescaler is half-way; a load must clear it.
        load = 1'b1; sel = 3'd4; step = 1'b0;
        cyc();
        load = 1'b0; step = 1'b1;
        cyc();
        total++; if (idx2 !== 3'd4) begin bad++; $display("FAIL div2_after_load got=%0d want=4", idx2); end
        cyc();
        step = 1'b0;
        total++; if (idx2 !== 3'd5) begin bad++; $display("FAIL div2_second got=%0d want=5", idx2); end
    endtask

    task automatic test_reset_mid();
        load = 1'b1; sel = 3'd6;
        cyc();
        load = 1'b0; step = 1'b1; dir = 1'b0;
        cyc();
        // dut1 now at 7, dut2 still at 6 with one step pending.
        total++; if (idx2 !== 3'd6) begin bad++; $display("FAIL mid_pre got=%0d want=6", idx2); end
        reset = 1'b1; load = 1'b1; sel = 3'd2; step = 1'b1;
        cyc();
        reset = 1'b0; load = 1'b0;
        total++; if (idx1 !== 3'd0 || out1 !== 8'h00 || valid1 !== 1'b0 || wrap1 !== 1'b0) begin
            bad++; $display("FAIL reset_mid got idx=%0d out=%h valid=%b wrap=%b want idx=0 out=00 valid=0 wrap=0",
                            idx1, out1, valid1, wrap1);
        end
        total++; if (valid2 !== 1'b0 || idx2 !== 3'd0) begin
            bad++; $display("FAIL reset_mid_div2 got idx=%0d valid=%b want idx=0 valid=0", idx2, valid2);
        end
        cyc();
        total++; if (idx1 !== 3'd0 || valid1 !== 1'b0) begin
            bad++; $display("FAIL step_after_reset got idx=%0d valid=%b want idx=0 valid=0", idx1, valid1);
        end
        // Partial prescale must have been discarded by reset.
        load = 1'b1; sel = 3'd6; step = 1'b0;
        cyc();
        load = 1'b0; step = 1'b1;
        cyc();
        step = 1'b0;
        total++; if (idx2 !== 3'd6) begin bad++; $display("FAIL reset_clears_pre got=%0d want=6", idx2); end
    endtask

    initial begin
        #2;
        test_reset();
        test_load();
        test_wrap();
        test_load_step();
        test_prescale();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
